// File: rtl/fpu_unpack_pkg.sv
// Shared constants, result record and helpers for the IEEE-754 operand unpacker.
// The normalization shifter is selected by the UNPACKER_NORMALIZE_EN macro in unpack_operand.
package fpu_unpack_pkg;

    localparam int DATA_W = 64;
    localparam int SIG_W  = 53;
    localparam int EXP_W  = 11;
    localparam int LZ_W   = 6;
    localparam int FLAG_W = 4;

    localparam int FLAG_ZERO = 3;
    localparam int FLAG_INF  = 2;
    localparam int FLAG_NAN  = 1;
    localparam int FLAG_SNAN = 0;

    localparam int DBL_BIAS    = 1023;
    localparam int SGL_BIAS    = 127;
    localparam int SGL_REBIAS  = DBL_BIAS - SGL_BIAS;

    localparam logic [SIG_W-1:0] QNAN_DEFAULT = 53'h18000000000000;

    // Decoded view of one operand, all fields in double-precision layout.
    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  expo;
        logic [SIG_W-1:0]  sig;
        logic [LZ_W-1:0]   lz;
        logic [FLAG_W-1:0] flags;
        logic [SIG_W-1:0]  qnan;
    } unpacked_t;

    // Leading-zero count of a 53-bit significand; an all-zero value reports 0.
    function automatic logic [LZ_W-1:0] lzc53(input logic [SIG_W-1:0] value);
        logic [LZ_W-1:0] count;
        count = 6'd0;
        for (int i = 0; i < SIG_W; i++) begin
            if (value[i]) begin
                count = LZ_W'(SIG_W - 1 - i);
            end else begin
                count = count;
            end
        end
        return count;
    endfunction

endpackage

// File: rtl/unpack_operand.sv
// Combinational decode of one packed single/double operand into sign, rebiased exponent,
// significand, leading-zero count, class flags and quiet-NaN payload. Macro: UNPACKER_NORMALIZE_EN.
module unpack_operand
    import fpu_unpack_pkg::*;
(
    input  logic [DATA_W-1:0] operand,
    input  logic              db,
    input  logic              normal,
    output unpacked_t         result
);

    logic              exp_zero_s;
    logic              exp_ones_s;
    logic [51:0]       frac_s;
    logic [EXP_W-1:0]  exp_s;
    logic [SIG_W-1:0]  sig_s;
    logic [LZ_W-1:0]   lz_s;
    logic              frac_nz_s;

    // Field extraction and exponent rebias; singles are left-aligned into the double fraction.
    always_comb begin
        exp_zero_s = 1'b0;
        exp_ones_s = 1'b0;
        frac_s     = 52'd0;
        exp_s      = 11'd0;
        if (db) begin
            exp_zero_s = (operand[62:52] == 11'd0);
            exp_ones_s = (operand[62:52] == 11'h7FF);
            frac_s     = operand[51:0];
            if (exp_zero_s) begin
                exp_s = 11'd1;
            end else begin
                exp_s = operand[62:52];
            end
        end else begin
            exp_zero_s = (operand[62:55] == 8'd0);
            exp_ones_s = (operand[62:55] == 8'hFF);
            frac_s     = {operand[54:32], 29'd0};
            if (exp_zero_s) begin
                exp_s = 11'd1;
            end else if (exp_ones_s) begin
                exp_s = 11'h7FF;
            end else begin
                exp_s = {3'b000, operand[62:55]} + EXP_W'(SGL_REBIAS);
            end
        end
    end

    assign frac_nz_s = (frac_s != 52'd0);
    assign sig_s     = {~exp_zero_s, frac_s};
    assign lz_s      = lzc53(sig_s);

`ifdef UNPACKER_NORMALIZE_EN
    logic [SIG_W-1:0] sig_out_s;

    // Optional normalization: shift out the leading zeros of denormal significands.
    always_comb begin
        if (normal) begin
            sig_out_s = sig_s << lz_s;
        end else begin
            sig_out_s = sig_s;
        end
    end
`else
    logic [SIG_W-1:0] sig_out_s;
    logic             unused_normal_s;

    assign unused_normal_s = normal;
    assign sig_out_s       = sig_s;
`endif

    // Assemble the decoded record, including class flags and the quieted NaN payload.
    always_comb begin
        result                  = '{default: 1'b0};
        result.sign             = operand[63];
        result.expo             = exp_s;
        result.sig              = sig_out_s;
        result.lz               = lz_s;
        result.flags[FLAG_ZERO] = exp_zero_s & ~frac_nz_s;
        result.flags[FLAG_INF]  = exp_ones_s & ~frac_nz_s;
        result.flags[FLAG_NAN]  = exp_ones_s & frac_nz_s;
        result.flags[FLAG_SNAN] = exp_ones_s & frac_nz_s & ~frac_s[51];
        result.qnan             = {2'b11, frac_s[50:0]};
    end

endmodule

// File: rtl/unpacker_master.sv
// Two-operand IEEE-754 unpacker with one-cycle registered outputs and NaN payload selection.
// Normalization of significands is available when UNPACKER_NORMALIZE_EN is defined.
module unpacker_master
    import fpu_unpack_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] FA2,
    input  logic [DATA_W-1:0] FB2,
    input  logic              db,
    input  logic              normal,
    output logic              sa,
    output logic              sb,
    output logic [EXP_W-1:0]  ea,
    output logic [EXP_W-1:0]  eb,
    output logic [LZ_W-1:0]   lza,
    output logic [LZ_W-1:0]   lzb,
    output logic [SIG_W-1:0]  fa,
    output logic [SIG_W-1:0]  fb,
    output logic [FLAG_W-1:0] fla,
    output logic [FLAG_W-1:0] flb,
    output logic [SIG_W-1:0]  nan
);

    unpacked_t        op_a_s;
    unpacked_t        op_b_s;
    logic [SIG_W-1:0] nan_sel_s;

    unpack_operand u_unpack_a (
        .operand (FA2),
        .db      (db),
        .normal  (normal),
        .result  (op_a_s)
    );

    unpack_operand u_unpack_b (
        .operand (FB2),
        .db      (db),
        .normal  (normal),
        .result  (op_b_s)
    );

    // NaN propagation: operand A has priority over B, otherwise the default quiet NaN.
    always_comb begin
        if (op_a_s.flags[FLAG_NAN]) begin
            nan_sel_s = op_a_s.qnan;
        end else if (op_b_s.flags[FLAG_NAN]) begin
            nan_sel_s = op_b_s.qnan;
        end else begin
            nan_sel_s = QNAN_DEFAULT;
        end
    end

    // Output registers with synchronous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            sa  <= 1'b0;
            sb  <= 1'b0;
            ea  <= 11'd0;
            eb  <= 11'd0;
            lza <= 6'd0;
            lzb <= 6'd0;
            fa  <= 53'd0;
            fb  <= 53'd0;
            fla <= 4'd0;
            flb <= 4'd0;
            nan <= 53'd0;
        end else begin
            sa  <= op_a_s.sign;
            sb  <= op_b_s.sign;
            ea  <= op_a_s.expo;
            eb  <= op_b_s.expo;
            lza <= op_a_s.lz;
            lzb <= op_b_s.lz;
            fa  <= op_a_s.sig;
            fb  <= op_b_s.sig;
            fla <= op_a_s.flags;
            flb <= op_b_s.flags;
            nan <= nan_sel_s;
        end
    end

endmodule

// File: tb/tb_unpacker_master.sv
// Directed-vector bench for unpacker_master; expected significands follow UNPACKER_NORMALIZE_EN.
module tb_unpacker_master;

    logic        clk;
    logic        rst;
    logic [63:0] FA2;
    logic [63:0] FB2;
    logic        db;
    logic        normal;
    logic        sa;
    logic        sb;
    logic [10:0] ea;
    logic [10:0] eb;
    logic [5:0]  lza;
    logic [5:0]  lzb;
    logic [52:0] fa;
    logic [52:0] fb;
    logic [3:0]  fla;
    logic [3:0]  flb;
    logic [52:0] nan;

    int n_checks;
    int n_fail;

`ifdef UNPACKER_NORMALIZE_EN
    localparam bit NORM_EN = 1'b1;
`else
    localparam bit NORM_EN = 1'b0;
`endif

    localparam logic [52:0] QNAN_DEF = 53'h18000000000000;
    localparam logic [52:0] HIDDEN   = 53'h10000000000000;

    unpacker_master dut (
        .clk    (clk),
        .rst    (rst),
        .FA2    (FA2),
        .FB2    (FB2),
        .db     (db),
        .normal (normal),
        .sa     (sa),
        .sb     (sb),
        .ea     (ea),
        .eb     (eb),
        .lza    (lza),
        .lzb    (lzb),
        .fa     (fa),
        .fb     (fb),
        .fla    (fla),
        .flb    (flb),
        .nan    (nan)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_equal(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_equal({tag, ".sa"},  64'(sa),  64'd0);
        check_equal({tag, ".sb"},  64'(sb),  64'd0);
        check_equal({tag, ".ea"},  64'(ea),  64'd0);
        check_equal({tag, ".eb"},  64'(eb),  64'd0);
        check_equal({tag, ".lza"}, 64'(lza), 64'd0);
        check_equal({tag, ".lzb"}, 64'(lzb), 64'd0);
        check_equal({tag, ".fa"},  64'(fa),  64'd0);
        check_equal({tag, ".fb"},  64'(fb),  64'd0);
        check_equal({tag, ".fla"}, 64'(fla), 64'd0);
        check_equal({tag, ".flb"}, 64'(flb), 64'd0);
        check_equal({tag, ".nan"}, 64'(nan), 64'd0);
    endtask

    task automatic run_vec(input string tag, input logic [63:0] a, input logic [63:0] b,
                           input logic d, input logic n,
                           input logic e_sa, input logic [10:0] e_ea, input logic [5:0] e_lza,
                           input logic [52:0] e_fa, input logic [3:0] e_fla,
                           input logic e_sb, input logic [10:0] e_eb, input logic [5:0] e_lzb,
                           input logic [52:0] e_fb, input logic [3:0] e_flb,
                           input logic [52:0] e_nan);
        rst    = 1'b0;
        FA2    = a;
        FB2    = b;
        db     = d;
        normal = n;
        @(posedge clk);
        #1;
        check_equal({tag, ".sa"},  64'(sa),  64'(e_sa));
        check_equal({tag, ".ea"},  64'(ea),  64'(e_ea));
        check_equal({tag, ".lza"}, 64'(lza), 64'(e_lza));
        check_equal({tag, ".fa"},  64'(fa),  64'(e_fa));
        check_equal({tag, ".fla"}, 64'(fla), 64'(e_fla));
        check_equal({tag, ".sb"},  64'(sb),  64'(e_sb));
        check_equal({tag, ".eb"},  64'(eb),  64'(e_eb));
        check_equal({tag, ".lzb"}, 64'(lzb), 64'(e_lzb));
        check_equal({tag, ".fb"},  64'(fb),  64'(e_fb));
        check_equal({tag, ".flb"}, 64'(flb), 64'(e_flb));
        check_equal({tag, ".nan"}, 64'(nan), 64'(e_nan));
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        FA2      = 64'h3F8921FB54447A7F;
        FB2      = 64'hFFF0000000000000;
        db       = 1'b1;
        normal   = 1'b1;
        @(posedge clk);
        #1;
        check_all_zero("reset");

        // Single-precision view of a double bit pattern
        run_vec("sgl_pi", 64'h3F8921FB54447A7F, 64'h3F8921FB54447A7F, 1'b0, 1'b1,
                1'b0, 11'h3FF, 6'd0, 53'h11243F60000000, 4'b0000,
                1'b0, 11'h3FF, 6'd0, 53'h11243F60000000, 4'b0000, QNAN_DEF);
        run_vec("dbl_pi", 64'h3F8921FB54447A7F, 64'h3F8921FB54447A7F, 1'b1, 1'b1,
                1'b0, 11'h3F8, 6'd0, 53'h1921FB54447A7F, 4'b0000,
                1'b0, 11'h3F8, 6'd0, 53'h1921FB54447A7F, 4'b0000, QNAN_DEF);
        // Denormals with the normalize request asserted, then deasserted
        run_vec("dbl_den_n1", 64'h0000000000000001, 64'h0008000000000000, 1'b1, 1'b1,
                1'b0, 11'h001, 6'd52, NORM_EN ? HIDDEN : 53'h1, 4'b0000,
                1'b0, 11'h001, 6'd1, NORM_EN ? HIDDEN : 53'h08000000000000, 4'b0000, QNAN_DEF);
        run_vec("dbl_den_n0", 64'h0000000000000001, 64'h0008000000000000, 1'b1, 1'b0,
                1'b0, 11'h001, 6'd52, 53'h1, 4'b0000,
                1'b0, 11'h001, 6'd1, 53'h08000000000000, 4'b0000, QNAN_DEF);
        run_vec("dbl_zero_inf", 64'h0000000000000000, 64'hFFF0000000000000, 1'b1, 1'b1,
                1'b0, 11'h001, 6'd0, 53'h0, 4'b1000,
                1'b1, 11'h7FF, 6'd0, HIDDEN, 4'b0100, QNAN_DEF);
        run_vec("dbl_nan", 64'h7FF0000000000001, 64'h7FF8000000000002, 1'b1, 1'b1,
                1'b0, 11'h7FF, 6'd0, 53'h10000000000001, 4'b0011,
                1'b0, 11'h7FF, 6'd0, 53'h18000000000002, 4'b0010, 53'h18000000000001);

        // Reset in the middle of a stream overrides the captured inputs
        FA2    = 64'h3F8921FB54447A7F;
        FB2    = 64'h3F8921FB54447A7F;
        db     = 1'b1;
        normal = 1'b1;
        rst    = 1'b1;
        @(posedge clk);
        #1;
        check_all_zero("mid_rst");
        run_vec("post_rst", 64'h3F8921FB54447A7F, 64'h3F8921FB54447A7F, 1'b1, 1'b1,
                1'b0, 11'h3F8, 6'd0, 53'h1921FB54447A7F, 4'b0000,
                1'b0, 11'h3F8, 6'd0, 53'h1921FB54447A7F, 4'b0000, QNAN_DEF);

        run_vec("sgl_bnan", 64'h3F8921FB54447A7F, 64'h7FC0000100000000, 1'b0, 1'b1,
                1'b0, 11'h3FF, 6'd0, 53'h11243F60000000, 4'b0000,
                1'b0, 11'h7FF, 6'd0, 53'h18000020000000, 4'b0010, 53'h18000020000000);
        run_vec("sgl_den_zero", 64'h0000000100000000, 64'h80000000DEADBEEF, 1'b0, 1'b1,
                1'b0, 11'h001, 6'd23, NORM_EN ? HIDDEN : 53'h20000000, 4'b0000,
                1'b1, 11'h001, 6'd0, 53'h0, 4'b1000, QNAN_DEF);
        run_vec("sgl_inf_min", 64'hFF80000000000000, 64'h0080000012345678, 1'b0, 1'b1,
                1'b1, 11'h7FF, 6'd0, HIDDEN, 4'b0100,
                1'b0, 11'h381, 6'd0, HIDDEN, 4'b0000, QNAN_DEF);
        run_vec("sgl_snan", 64'h7F80000100000000, 64'h0000000000000000, 1'b0, 1'b1,
                1'b0, 11'h7FF, 6'd0, 53'h10000020000000, 4'b0011,
                1'b0, 11'h001, 6'd0, 53'h0, 4'b1000, 53'h18000020000000);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
